// File: rtl/fadd_ctrl_pkg.sv
// Shared types and default constants for the shared floating-point adder controller.
// Requester slot states and the in-flight tag carried alongside the adder pipeline.
package fadd_ctrl_pkg;

    localparam int N_DEF   = 16;
    localparam int LAT_DEF = 3;
    localparam int EXP_W   = 8;
    localparam int MAN_W   = 7;
    // Wide enough for the largest supported requester count (16).
    localparam int MAX_IDW = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FLIGHT = 2'd1,
        HOLD   = 2'd2
    } slot_state_t;

    typedef struct packed {
        logic               valid;
        logic [MAX_IDW-1:0] id;
    } tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first eligible index at or after the pointer.
// The pointer moves just past the winner whenever a grant is taken.
module rr_arbiter #(
    parameter  int NREQ = 4,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [NREQ-1:0] i_eligible,
    input  logic            i_advance,
    output logic [NREQ-1:0] o_grant,
    output logic [IDW-1:0]  o_grant_idx,
    output logic            o_any_grant
);

    localparam logic [IDW-1:0] LAST_IDX = IDW'(NREQ - 1);
    localparam logic [IDW-1:0] IDX_ONE  = IDW'(1);

    logic [IDW-1:0] r_ptr;

    // NOTE: every variable driven here gets a default first, so no latch is inferred.
    always_comb begin
        int j;
        j           = 0;
        o_grant     = '0;
        o_grant_idx = '0;
        o_any_grant = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            j = (int'(r_ptr) + k) % NREQ;
            if (!o_any_grant && i_eligible[j]) begin
                o_any_grant = 1'b1;
                o_grant[j]  = 1'b1;
                o_grant_idx = IDW'(j);
            end
        end
    end

    // NOTE: flops use non-blocking assignment so every reader sees pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_ptr <= '0;
        end else if (i_advance && o_any_grant) begin
            r_ptr <= (o_grant_idx == LAST_IDX) ? '0 : o_grant_idx + IDX_ONE;
        end
    end

endmodule

// File: rtl/fadd_share_ctrl.sv
// Shares one fixed-latency pipelined FP adder between NREQ requesters.
// A tag pipeline mirrors the adder so each result lands in its owner's hold register.
module fadd_share_ctrl
    import fadd_ctrl_pkg::*;
#(
    parameter  int N    = N_DEF,
    parameter  int NREQ = 4,
    parameter  int LAT  = LAT_DEF,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*N-1:0] req_a,
    input  logic [NREQ*N-1:0] req_b,
    output logic [NREQ-1:0]   req_ready,
    output logic [NREQ-1:0]   rsp_valid,
    output logic [NREQ*N-1:0] rsp_sum,
    input  logic [NREQ-1:0]   rsp_ready,
    output logic [N-1:0]      add_a,
    output logic [N-1:0]      add_b,
    output logic              add_start,
    input  logic [N-1:0]      add_sum,
    output logic [IDW:0]      inflight
);

    localparam int            MAX_INFLIGHT = (NREQ < LAT) ? NREQ : LAT;
    localparam logic [IDW:0]  INF_ONE      = (IDW+1)'(1);

    slot_state_t       r_slot [NREQ];
    tag_t              r_tag  [LAT];
    logic [NREQ-1:0]   r_rsp_valid;
    logic [NREQ*N-1:0] r_rsp_sum;
    logic [IDW:0]      r_inflight;

    logic [NREQ-1:0]   w_eligible;
    logic [NREQ-1:0]   w_grant;
    logic [IDW-1:0]    w_grant_idx;
    logic              w_any_grant;
    logic              w_issue;
    logic              w_cap;
    logic [NREQ-1:0]   w_cap_hit;

    always_comb begin
        w_eligible = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_eligible[i] = req_valid[i] && (r_slot[i] == IDLE);
        end
    end

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .clock       (clock),
        .reset       (reset),
        .i_eligible  (w_eligible),
        .i_advance   (w_issue),
        .o_grant     (w_grant),
        .o_grant_idx (w_grant_idx),
        .o_any_grant (w_any_grant)
    );

    // Handshake outputs are forced low while reset is held, even though slots read IDLE.
    assign w_issue   = w_any_grant && !reset;
    assign req_ready = w_grant & {NREQ{!reset}};
    assign add_start = w_issue;

    always_comb begin
        add_a = '0;
        add_b = '0;
        if (w_issue) begin
            add_a = req_a[int'(w_grant_idx)*N +: N];
            add_b = req_b[int'(w_grant_idx)*N +: N];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < LAT; s++) begin
                r_tag[s] <= '0;
            end
        end else begin
            r_tag[0] <= '{valid: w_issue, id: MAX_IDW'(w_grant_idx)};
            for (int s = 1; s < LAT; s++) begin
                r_tag[s] <= r_tag[s-1];
            end
        end
    end

    assign w_cap = r_tag[LAT-1].valid;

    always_comb begin
        w_cap_hit = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_cap_hit[i] = w_cap && (r_tag[LAT-1].id == MAX_IDW'(i));
        end
    end

    // NOTE: the result registers are reset because their value is visible on rsp_sum.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREQ; i++) begin
                r_slot[i] <= IDLE;
            end
            r_rsp_valid <= '0;
            r_rsp_sum   <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                case (r_slot[i])
                    IDLE: begin
                        if (w_issue && w_grant[i]) r_slot[i] <= FLIGHT;
                    end
                    FLIGHT: begin
                        if (w_cap_hit[i]) begin
                            r_slot[i]          <= HOLD;
                            r_rsp_valid[i]     <= 1'b1;
                            r_rsp_sum[i*N +: N] <= add_sum;
                        end
                    end
                    HOLD: begin
                        if (rsp_ready[i]) begin
                            r_slot[i]      <= IDLE;
                            r_rsp_valid[i] <= 1'b0;
                        end
                    end
                    default: r_slot[i] <= IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_inflight <= '0;
        end else begin
            case ({w_issue, w_cap})
                2'b10:   r_inflight <= r_inflight + INF_ONE;
                2'b01:   r_inflight <= r_inflight - INF_ONE;
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_sum   = r_rsp_sum;
    assign inflight  = r_inflight;

    // A returning tag must always find its owner waiting in FLIGHT.
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_cap_chk
        a_cap_owner: assert property (@(posedge clock) disable iff (reset)
            w_cap_hit[gi] |-> (r_slot[gi] == FLIGHT));
    end

    a_inflight_max: assert property (@(posedge clock) disable iff (reset)
        r_inflight <= (IDW+1)'(MAX_INFLIGHT));

endmodule

// File: tb/tb_fadd_share_ctrl.sv
// Self-checking bench: behavioural LAT-cycle bfloat16 adder plus a transaction-level
// reference model of arbitration, result latency and occupancy.
module tb_fadd_share_ctrl;

    localparam int N    = 16;
    localparam int NREQ = 4;
    localparam int LAT  = 3;
    localparam int IDW  = 2;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic [NREQ-1:0]   req_valid = '0;
    logic [NREQ*N-1:0] req_a = '0;
    logic [NREQ*N-1:0] req_b = '0;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ-1:0]   rsp_valid;
    logic [NREQ*N-1:0] rsp_sum;
    logic [NREQ-1:0]   rsp_ready = '0;
    logic [N-1:0]      add_a;
    logic [N-1:0]      add_b;
    logic              add_start;
    logic [N-1:0]      add_sum;
    logic [IDW:0]      inflight;

    int n_checks = 0;
    int n_fail   = 0;

    fadd_share_ctrl #(.N(N), .NREQ(NREQ), .LAT(LAT)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_sum(rsp_sum), .rsp_ready(rsp_ready),
        .add_a(add_a), .add_b(add_b), .add_start(add_start), .add_sum(add_sum),
        .inflight(inflight)
    );

    always #5 clock = ~clock;

    // bfloat16 arithmetic through doubles (normal operands; mantissa truncated).
    function automatic real bf_to_real(input logic [15:0] x);
        logic [63:0] d;
        if (x[14:7] == 8'd0) return 0.0;
        d = {x[15], 11'({3'b000, x[14:7]}) + 11'd896, x[6:0], 45'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [15:0] bf_add(input logic [15:0] a, input logic [15:0] b);
        real         s;
        logic [63:0] d;
        logic [10:0] e;
        s = bf_to_real(a) + bf_to_real(b);
        if (s == 0.0) return 16'h0000;
        d = $realtobits(s);
        e = d[62:52] - 11'd896;
        return {d[63], e[7:0], d[51:45]};
    endfunction

    function automatic logic [15:0] rand_bf();
        logic [7:0] e;
        e = 8'(120 + $urandom_range(0, 14));
        return {1'($urandom), e, 7'($urandom)};
    endfunction

    function automatic logic [NREQ*N-1:0] rand_vec();
        logic [NREQ*N-1:0] v;
        for (int i = 0; i < NREQ; i++) v[i*N +: N] = rand_bf();
        return v;
    endfunction

    // Behavioural adder: result appears LAT edges after the issue edge; garbage otherwise.
    logic [N-1:0] add_pipe [LAT] = '{default: '0};
    always @(posedge clock) begin
        add_pipe[0] <= add_start ? bf_add(add_a, add_b) : N'($urandom);
        for (int s = 1; s < LAT; s++) add_pipe[s] <= add_pipe[s-1];
    end
    assign add_sum = add_pipe[LAT-1];

    // Reference model: per-requester busy flag, accept edge and expected sum.
    bit              busy [NREQ];
    int              acc_edge [NREQ];
    logic [N-1:0]    exp_sum [NREQ];
    int              ptr   = 0;
    int              edges = 0;
    logic [NREQ-1:0] exp_ready;
    logic [NREQ-1:0] exp_rvalid;
    int              exp_inflight;

    task automatic model_reset();
        for (int i = 0; i < NREQ; i++) begin
            busy[i] = 1'b0;
            acc_edge[i] = 0;
        end
        ptr = 0;
    endtask

    task automatic drive(input logic [NREQ-1:0] v, input logic [NREQ-1:0] rr,
                         input logic [NREQ*N-1:0] a, input logic [NREQ*N-1:0] b);
        int j;
        req_valid = v;
        rsp_ready = rr;
        req_a     = a;
        req_b     = b;
        exp_ready = '0;
        exp_rvalid = '0;
        exp_inflight = 0;
        if (!reset) begin
            for (int k = 0; k < NREQ; k++) begin
                j = (ptr + k) % NREQ;
                if (exp_ready == '0 && v[j] && !busy[j]) exp_ready[j] = 1'b1;
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (busy[i] && (edges - acc_edge[i] >= LAT)) exp_rvalid[i] = 1'b1;
            if (busy[i] && (edges - acc_edge[i] <  LAT)) exp_inflight++;
        end
        #1;
    endtask

    task automatic tick();
        @(posedge clock);
        edges++;
        if (reset) begin
            model_reset();
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (exp_ready[i]) begin
                    busy[i]     = 1'b1;
                    acc_edge[i] = edges;
                    exp_sum[i]  = bf_add(req_a[i*N +: N], req_b[i*N +: N]);
                    ptr         = (i + 1) % NREQ;
                end else if (exp_rvalid[i] && rsp_ready[i]) begin
                    busy[i] = 1'b0;
                end
            end
        end
        @(negedge clock);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        drive('0, '0, '0, '0);
        tick();
        reset = 1'b0;
        drive('0, '0, '0, '0);
    endtask

    task automatic drain();
        for (int c = 0; c < LAT + 3; c++) begin
            drive('0, '1, '0, '0);
            tick();
        end
    endtask

    task automatic test_reset();
        for (int c = 0; c < 2; c++) begin
            drive('1, '1, rand_vec(), rand_vec());
            n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_req_ready: got %b want 0000", req_ready); end
            n_checks++; if (add_start !== 1'b0 || add_a !== '0 || add_b !== '0) begin n_fail++; $display("FAIL reset_add: start=%b a=%h b=%h want 0/0/0", add_start, add_a, add_b); end
            n_checks++; if (rsp_valid !== 4'b0000 || rsp_sum !== '0) begin n_fail++; $display("FAIL reset_rsp: valid=%b sum=%h want zeros", rsp_valid, rsp_sum); end
            n_checks++; if (inflight !== '0) begin n_fail++; $display("FAIL reset_inflight: got %0d want 0", inflight); end
            tick();
        end
        reset = 1'b0;
        drive('0, '0, '0, '0);
    endtask

    task automatic test_single();
        logic [NREQ*N-1:0] a = '0;
        logic [NREQ*N-1:0] b = '0;
        a[15:0] = 16'h3F80;
        b[15:0] = 16'h4000;
        drive(4'b0001, '0, a, b);
        n_checks++; if (req_ready !== 4'b0001 || add_start !== 1'b1) begin n_fail++; $display("FAIL single_issue: ready=%b start=%b want 0001/1", req_ready, add_start); end
        n_checks++; if (add_a !== 16'h3F80 || add_b !== 16'h4000) begin n_fail++; $display("FAIL single_operands: a=%h b=%h want 3f80/4000", add_a, add_b); end
        tick();
        for (int c = 1; c <= LAT + 3; c++) begin
            drive('0, '0, rand_vec(), rand_vec());
            n_checks++; if (add_start !== 1'b0) begin n_fail++; $display("FAIL single_one_pulse: start=%b at cycle %0d want 0", add_start, c); end
            n_checks++; if (rsp_valid !== ((c >= LAT + 1) ? 4'b0001 : 4'b0000)) begin n_fail++; $display("FAIL single_latency: rsp_valid=%b at cycle %0d", rsp_valid, c); end
            n_checks++; if (inflight !== ((c <= LAT) ? 3'd1 : 3'd0)) begin n_fail++; $display("FAIL single_inflight: got %0d at cycle %0d", inflight, c); end
            if (c >= LAT + 1) begin
                n_checks++; if (rsp_sum[15:0] !== 16'h4040) begin n_fail++; $display("FAIL single_sum: got %h want 4040", rsp_sum[15:0]); end
            end
            tick();
        end
        drive('0, 4'b0001, '0, '0);
        tick();
        drive('0, '0, '0, '0);
        n_checks++; if (rsp_valid !== 4'b0000) begin n_fail++; $display("FAIL single_consume: rsp_valid=%b want 0000", rsp_valid); end
    endtask

    task automatic test_all_four();
        logic [NREQ-1:0]   granted = '0;
        logic [NREQ-1:0]   want_g;
        logic [NREQ*N-1:0] a, b;
        logic [N-1:0]      want [NREQ];
        int                peak = 0;
        int                done = 0;
        do_reset();
        for (int c = 0; c < 12; c++) begin
            a = rand_vec();
            b = rand_vec();
            drive(4'hF & ~granted, 4'hF, a, b);
            if (c < NREQ) begin
                want_g = 4'b0001 << c;
                n_checks++; if (req_ready !== want_g) begin n_fail++; $display("FAIL all4_order: cycle %0d ready=%b want %b", c, req_ready, want_g); end
            end
            if (int'(inflight) > peak) peak = int'(inflight);
            for (int i = 0; i < NREQ; i++) begin
                if (req_ready[i]) begin
                    want[i] = bf_add(a[i*N +: N], b[i*N +: N]);
                    granted[i] = 1'b1;
                end
                if (rsp_valid[i]) begin
                    done++;
                    n_checks++; if (rsp_sum[i*N +: N] !== want[i]) begin n_fail++; $display("FAIL all4_sum: req %0d got %h want %h", i, rsp_sum[i*N +: N], want[i]); end
                end
            end
            tick();
        end
        n_checks++; if (peak !== 3) begin n_fail++; $display("FAIL all4_peak: inflight peak %0d want 3", peak); end
        n_checks++; if (done !== 4) begin n_fail++; $display("FAIL all4_done: %0d results want 4", done); end
    endtask

    task automatic test_hold();
        logic [NREQ*N-1:0] a, b;
        logic [N-1:0]      want2;
        int                served = 0;
        a = rand_vec();
        b = rand_vec();
        drive(4'b0100, 4'b1011, a, b);
        want2 = bf_add(a[47:32], b[47:32]);
        n_checks++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL hold_grant: ready=%b want 0100", req_ready); end
        tick();
        for (int c = 0; c < LAT; c++) begin
            drive('0, 4'b1011, '0, '0);
            tick();
        end
        for (int c = 0; c < 10; c++) begin
            drive(4'hF, 4'b1011, rand_vec(), rand_vec());
            n_checks++; if (req_ready[2] !== 1'b0 || rsp_valid[2] !== 1'b1) begin n_fail++; $display("FAIL hold_slot2: ready=%b valid=%b want 0/1", req_ready[2], rsp_valid[2]); end
            n_checks++; if (rsp_sum[47:32] !== want2) begin n_fail++; $display("FAIL hold_stable: got %h want %h", rsp_sum[47:32], want2); end
            n_checks++; if (req_ready !== exp_ready) begin n_fail++; $display("FAIL hold_rr: ready=%b want %b", req_ready, exp_ready); end
            served += $countones(req_ready);
            tick();
        end
        n_checks++; if (served < 3) begin n_fail++; $display("FAIL hold_others_served: %0d grants want >=3", served); end
        drain();
        n_checks++; if (rsp_valid !== 4'b0000 || inflight !== '0) begin n_fail++; $display("FAIL hold_drain: valid=%b inflight=%0d want 0/0", rsp_valid, inflight); end
    endtask

    task automatic test_same_cycle();
        drive(4'b0010, '0, rand_vec(), rand_vec());
        n_checks++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL same_first_grant: ready=%b want 0010", req_ready); end
        tick();
        for (int c = 0; c < LAT; c++) begin
            drive('0, '0, '0, '0);
            tick();
        end
        drive(4'b0010, 4'b0010, rand_vec(), rand_vec());
        n_checks++; if (rsp_valid[1] !== 1'b1 || req_ready !== 4'b0000) begin n_fail++; $display("FAIL same_no_bypass: valid=%b ready=%b want 1/0000", rsp_valid[1], req_ready); end
        tick();
        drive(4'b0010, '0, rand_vec(), rand_vec());
        n_checks++; if (req_ready !== 4'b0010 || rsp_valid[1] !== 1'b0) begin n_fail++; $display("FAIL same_next_grant: ready=%b valid=%b want 0010/0", req_ready, rsp_valid[1]); end
        tick();
        drain();
    endtask

    task automatic test_wrap();
        logic [NREQ-1:0] w;
        do_reset();
        for (int r = 0; r < 3; r++) begin
            w = 4'b0001 << r;
            drive(w, '1, rand_vec(), rand_vec());
            n_checks++; if (req_ready !== w) begin n_fail++; $display("FAIL wrap_setup: ready=%b want %b", req_ready, w); end
            tick();
        end
        drain();
        drive(4'b1001, '1, rand_vec(), rand_vec());
        n_checks++; if (req_ready !== 4'b1000) begin n_fail++; $display("FAIL wrap_first: ready=%b want 1000", req_ready); end
        tick();
        drive(4'b1001, '1, rand_vec(), rand_vec());
        n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL wrap_second: ready=%b want 0001", req_ready); end
        tick();
        drain();
    endtask

    task automatic test_reset_midflight();
        for (int c = 0; c < 3; c++) begin
            drive(4'b1110, '0, rand_vec(), rand_vec());
            tick();
        end
        drive('1, '0, rand_vec(), rand_vec());
        n_checks++; if (inflight !== 3'd3) begin n_fail++; $display("FAIL midrst_pre: inflight=%0d want 3", inflight); end
        reset = 1'b1;
        #1;
        n_checks++; if (req_ready !== '0 || add_start !== 1'b0 || add_a !== '0 || add_b !== '0) begin n_fail++; $display("FAIL midrst_comb: ready=%b start=%b a=%h want zeros", req_ready, add_start, add_a); end
        n_checks++; if (rsp_valid !== '0 || inflight !== '0 || rsp_sum !== '0) begin n_fail++; $display("FAIL midrst_regs: valid=%b inflight=%0d want zeros", rsp_valid, inflight); end
        reset = 1'b0;
        model_reset();
        for (int c = 0; c < LAT + 2; c++) begin
            drive('0, '0, '0, '0);
            n_checks++; if (rsp_valid !== '0 || inflight !== '0) begin n_fail++; $display("FAIL midrst_stale: cycle %0d valid=%b inflight=%0d want 0/0", c, rsp_valid, inflight); end
            tick();
        end
    endtask

    task automatic test_random();
        logic [N-1:0] ga;
        for (int c = 0; c < 400; c++) begin
            drive(NREQ'($urandom), NREQ'($urandom), rand_vec(), rand_vec());
            n_checks++; if (req_ready !== exp_ready) begin n_fail++; $display("FAIL rand_ready: cycle %0d got %b want %b", c, req_ready, exp_ready); end
            n_checks++; if (rsp_valid !== exp_rvalid) begin n_fail++; $display("FAIL rand_rsp_valid: cycle %0d got %b want %b", c, rsp_valid, exp_rvalid); end
            n_checks++; if (int'(inflight) !== exp_inflight) begin n_fail++; $display("FAIL rand_inflight: cycle %0d got %0d want %0d", c, inflight, exp_inflight); end
            ga = '0;
            for (int i = 0; i < NREQ; i++) if (exp_ready[i]) ga = req_a[i*N +: N];
            n_checks++; if (add_start !== (exp_ready != '0) || add_a !== ga) begin n_fail++; $display("FAIL rand_issue: cycle %0d start=%b a=%h want a=%h", c, add_start, add_a, ga); end
            for (int i = 0; i < NREQ; i++) begin
                if (exp_rvalid[i]) begin
                    n_checks++; if (rsp_sum[i*N +: N] !== exp_sum[i]) begin n_fail++; $display("FAIL rand_sum: cycle %0d req %0d got %h want %h", c, i, rsp_sum[i*N +: N], exp_sum[i]); end
                end
            end
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_all_four();
        test_hold();
        test_same_cycle();
        test_wrap();
        test_reset_midflight();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
